// File: rtl/memory_access_if.sv
// memory_access_if: shared types and the stage bus bundle
// Package memory_access_pkg holds the pipeline and data-bus structs.
// Interface memory_access_if bundles:
//   dataE  execute-stage result into the memory stage
//   dresp  data-bus response
//   dreq   data-bus request
//   dataM  memory-stage result to writeback
//   stallM upstream hold
// Modport slave is the memory stage; modport master is its environment.
package memory_access_pkg;
    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] mcause;
        logic [63:0] mtval;
    } excep_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        ctl_t        ctl;
        logic [63:0] aluout;
        logic [63:0] memwd;
        excep_t      excep;
        logic [11:0] csr_addr;
        logic [63:0] csr_data;
        logic [1:0]  priviledge_mode;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        logic [4:0]  dst;
        ctl_t        ctl;
        logic [63:0] aluout;
        excep_t      excep;
        logic [11:0] csr_addr;
        logic [63:0] csr_data;
        logic [1:0]  priviledge_mode;
        logic        skip;
    } memory_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

interface memory_access_if;
    import memory_access_pkg::*;
    execute_data_t dataE;
    dbus_resp_t    dresp;
    dbus_req_t     dreq;
    memory_data_t  dataM;
    logic          stallM;

    modport slave (input dataE, input dresp, output dreq, output dataM, output stallM);
    modport master (output dataE, output dresp, input dreq, input dataM, input stallM);
endinterface

// File: rtl/memory_access.sv
// memory_access: memory stage between execute and writeback
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    memory_access_if.slave (dataE, dresp in; dreq, dataM, stallM out)
// Issues load/store requests through an IDLE/BUSY FSM, aligns and extends load data,
// flags misaligned accesses and holds the pipeline until data_ok.
module memory_access
    import memory_access_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1,
    parameter int MMIO_BIT    = 31
) (
    input logic             clk,
    input logic             reset,
    memory_access_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_n;
    logic memop, misalign, mis_exc, go, stall_raw, busy;
    logic [2:0] funct3, off;
    logic [1:0] size;
    logic [5:0] sh;
    logic [7:0] mask;
    logic [63:0] addr, raw, ld;
    logic unused_addr_ok;

    assign unused_addr_ok = bus.dresp.addr_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        busy = state == BUSY;
        memop = bus.dataE.valid & (bus.dataE.ctl.memread | bus.dataE.ctl.memwrite);
        funct3 = bus.dataE.raw_instr[14:12];
        size = funct3[1:0];
        addr = bus.dataE.aluout;
        off = addr[2:0];
        sh = {off, 3'b000};
        misalign = CHECK_ALIGN & ((size == 2'd1 & off[0]) | (size == 2'd2 & off[1:0] != 2'd0)
                                | (size == 2'd3 & off != 3'd0));
        mis_exc = memop & misalign & ~bus.dataE.excep.valid;
        go = memop & ~misalign & ~bus.dataE.excep.valid;
        // IDLE always spends one stall cycle on a request; only BUSY observes data_ok
        stall_raw = busy ? ~bus.dresp.data_ok : go;
        state_n = busy ? (bus.dresp.data_ok ? IDLE : BUSY) : (go ? BUSY : IDLE);
        mask = size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0F : 8'hFF;
        raw = bus.dresp.data >> sh;
        ld = funct3 == 3'd0 ? {{56{raw[7]}}, raw[7:0]}
           : funct3 == 3'd1 ? {{48{raw[15]}}, raw[15:0]}
           : funct3 == 3'd2 ? {{32{raw[31]}}, raw[31:0]}
           : funct3 == 3'd4 ? {56'd0, raw[7:0]}
           : funct3 == 3'd5 ? {48'd0, raw[15:0]}
           : funct3 == 3'd6 ? {32'd0, raw[31:0]}
           : raw;
        bus.dreq = '0;
        bus.dreq.valid = ~reset & (busy | go);
        bus.dreq.addr = addr;
        bus.dreq.size = {1'b0, size};
        bus.dreq.strobe = bus.dataE.ctl.memwrite ? mask << off : 8'h00;
        bus.dreq.data = bus.dataE.ctl.memwrite ? bus.dataE.memwd << sh : 64'd0;
        bus.stallM = ~reset & stall_raw;
        bus.dataM = '0;
        bus.dataM.valid = ~reset & bus.dataE.valid & ~stall_raw;
        bus.dataM.pc = bus.dataE.pc;
        bus.dataM.raw_instr = bus.dataE.raw_instr;
        bus.dataM.dst = bus.dataE.dst;
        bus.dataM.ctl = bus.dataE.valid ? bus.dataE.ctl : '0;
        bus.dataM.ctl.regwrite = bus.dataE.valid & bus.dataE.ctl.regwrite & ~mis_exc;
        bus.dataM.aluout = busy & bus.dataE.ctl.memread ? ld : addr;
        bus.dataM.excep = bus.dataE.excep.valid ? bus.dataE.excep
                        : mis_exc ? '{valid: 1'b1, mcause: bus.dataE.ctl.memread ? 64'd4 : 64'd6, mtval: addr}
                        : '0;
        bus.dataM.csr_addr = bus.dataE.csr_addr;
        bus.dataM.csr_data = bus.dataE.csr_data;
        bus.dataM.priviledge_mode = bus.dataE.priviledge_mode;
        bus.dataM.skip = memop & ~addr[MMIO_BIT];
    end
endmodule
